// File: rtl/bus6502_master.sv
// 6502/NES cartridge-side bus initiator: free-running M2, one transaction in flight, valid/ready request and response.
// Optional macro BUS6502_RDY_EN adds c6502_rdy read-stall support.
module bus6502_master #(
    parameter int ADDR_W        = 15,
    parameter int PHI_LO_CYCLES = 10,
    parameter int PHI_HI_CYCLES = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              resp_valid,
    output logic [7:0]        resp_rdata,
    output logic              c6502_m2,
    output logic [ADDR_W-1:0] c6502_addr,
    output logic              c6502_rw,
    output logic [7:0]        c6502_data_out,
    output logic              c6502_data_oe,
`ifdef BUS6502_RDY_EN
    input  logic              c6502_rdy,
`endif
    input  logic [7:0]        c6502_data_in
);

    localparam int CNT_MAX = (PHI_LO_CYCLES > PHI_HI_CYCLES) ? PHI_LO_CYCLES : PHI_HI_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    typedef enum logic {LOW, HIGH} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              m2_reg;
    logic              rw_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        wdata_reg;
    logic              oe_reg;
    logic              resp_valid_reg;
    logic [7:0]        rdata_reg;
    logic              busy_reg;
    logic              stall_reg;
    logic              rdy_ok;
    logic              slot, lo_end, hi_end;

`ifdef BUS6502_RDY_EN
    assign rdy_ok = c6502_rdy;
`else
    assign rdy_ok = 1'b1;
`endif

    assign slot   = (state_reg == LOW)  && (cnt_reg == '0);
    assign lo_end = (state_reg == LOW)  && (cnt_reg == CNT_W'(PHI_LO_CYCLES - 1));
    assign hi_end = (state_reg == HIGH) && (cnt_reg == CNT_W'(PHI_HI_CYCLES - 1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        if (lo_end) begin
            state_next = HIGH;
            cnt_next   = '0;
        end else if (hi_end) begin
            state_next = LOW;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= LOW;
            cnt_reg        <= '0;
            m2_reg         <= 1'b0;
            rw_reg         <= 1'b1;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            oe_reg         <= 1'b0;
            resp_valid_reg <= 1'b0;
            rdata_reg      <= '0;
            busy_reg       <= 1'b0;
            stall_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            m2_reg         <= (state_next == HIGH);
            resp_valid_reg <= 1'b0;

            // Accept slot: the data hold after the previous M2 fall ends here too.
            if (slot) begin
                oe_reg <= 1'b0;
                if (stall_reg) begin
                    rw_reg   <= 1'b1;
                    busy_reg <= 1'b1;
                end else if (req_valid) begin
                    rw_reg    <= req_rw;
                    addr_reg  <= req_addr;
                    wdata_reg <= req_wdata;
                    busy_reg  <= 1'b1;
                end else begin
                    rw_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                end
            end

            if (lo_end && busy_reg && !rw_reg)
                oe_reg <= 1'b1;

            if (hi_end && busy_reg) begin
                if (rw_reg && !rdy_ok) begin
                    stall_reg <= 1'b1;
                end else begin
                    stall_reg      <= 1'b0;
                    resp_valid_reg <= 1'b1;
                    if (rw_reg)
                        rdata_reg <= c6502_data_in;
                end
            end
        end
    end

    // Decoded from registered state only; no path from req_valid.
    assign req_ready      = slot && !stall_reg;
    assign resp_valid     = resp_valid_reg;
    assign resp_rdata     = rdata_reg;
    assign c6502_m2       = m2_reg;
    assign c6502_addr     = addr_reg;
    assign c6502_rw       = rw_reg;
    assign c6502_data_out = wdata_reg;
    assign c6502_data_oe  = oe_reg;

endmodule

// File: tb/tb_bus6502_master.sv
// Directed bench for bus6502_master: reset, M2 timing, read, write, back-to-back, idle, mid-cycle reset, optional RDY stall.
module tb_bus6502_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b1;
    logic [14:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        c6502_m2;
    logic [14:0] c6502_addr;
    logic        c6502_rw;
    logic [7:0]  c6502_data_out;
    logic        c6502_data_oe;
    logic [7:0]  c6502_data_in = '0;
`ifdef BUS6502_RDY_EN
    logic        c6502_rdy = 1'b1;
`endif

    int checks = 0;
    int passes = 0;
    int resp_count = 0;

    always #5 clk = ~clk;

    bus6502_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .c6502_m2(c6502_m2), .c6502_addr(c6502_addr), .c6502_rw(c6502_rw),
        .c6502_data_out(c6502_data_out), .c6502_data_oe(c6502_data_oe),
`ifdef BUS6502_RDY_EN
        .c6502_rdy(c6502_rdy),
`endif
        .c6502_data_in(c6502_data_in)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (resp_valid) resp_count++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        check("ready_timeout", 32'(n < 100), 32'd1);
    endtask

    initial begin
        int n;
        int rises;
        int oe_seen;
        int rw_bad;
        logic m2_prev;

        // Reset and free-running M2
        ticks(3);
        rst = 1'b0;
        check("rst_m2", 32'(c6502_m2), 32'd0);
        check("rst_rw", 32'(c6502_rw), 32'd1);
        check("rst_addr", 32'(c6502_addr), 32'd0);
        check("rst_oe", 32'(c6502_data_oe), 32'd0);
        check("rst_resp", 32'(resp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        ticks(9);
        check("m2_low_9", 32'(c6502_m2), 32'd0);
        tick();
        check("m2_rise_10", 32'(c6502_m2), 32'd1);
        ticks(10);
        check("m2_fall_20", 32'(c6502_m2), 32'd0);
        ticks(10);
        check("m2_period_rise", 32'(c6502_m2), 32'd1);

        // Read at 7FFC
        wait_ready();
        c6502_data_in = 8'h4C;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 15'h7FFC; req_wdata = 8'h00;
        check("rd_addr_before", 32'(c6502_addr), 32'd0);
        resp_count = 0;
        tick();
        req_valid = 1'b0;
        check("rd_addr_cnt1", 32'(c6502_addr), 32'h7FFC);
        check("rd_rw", 32'(c6502_rw), 32'd1);
        n = 1; oe_seen = 0;
        while (!resp_valid && n < 60) begin
            tick();
            n++;
            if (c6502_data_oe) oe_seen = 1;
        end
        // resp_valid is seen by the consumer at the same edge as the next accept slot.
        check("rd_latency", 32'(n), 32'd20);
        check("rd_oe_never", 32'(oe_seen), 32'd0);
        check("rd_rdata", 32'(resp_rdata), 32'h4C);
        check("rd_ready_with_resp", 32'(req_ready), 32'd1);
        check("rd_addr_hold", 32'(c6502_addr), 32'h7FFC);
        tick();
        check("rd_resp_one_clk", 32'(resp_valid), 32'd0);
        check("rd_resp_count", 32'(resp_count), 32'd1);

        // Write A5 to 0200
        wait_ready();
        c6502_data_in = 8'hEE;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 15'h0200; req_wdata = 8'hA5;
        resp_count = 0;
        tick();
        req_valid = 1'b0;
        check("wr_rw", 32'(c6502_rw), 32'd0);
        check("wr_addr", 32'(c6502_addr), 32'h0200);
        check("wr_data", 32'(c6502_data_out), 32'hA5);
        check("wr_oe_low", 32'(c6502_data_oe), 32'd0);
        ticks(8);
        check("wr_oe_before_rise", 32'(c6502_data_oe), 32'd0);
        tick();
        check("wr_m2_rise", 32'(c6502_m2), 32'd1);
        check("wr_oe_at_rise", 32'(c6502_data_oe), 32'd1);
        ticks(9);
        check("wr_oe_high_end", 32'(c6502_data_oe), 32'd1);
        check("wr_no_early_resp", 32'(resp_valid), 32'd0);
        tick();
        check("wr_m2_fall", 32'(c6502_m2), 32'd0);
        check("wr_oe_hold", 32'(c6502_data_oe), 32'd1);
        check("wr_resp", 32'(resp_valid), 32'd1);
        check("wr_rdata_kept", 32'(resp_rdata), 32'h4C);
        check("wr_rw_hold", 32'(c6502_rw), 32'd0);
        tick();
        check("wr_oe_clear", 32'(c6502_data_oe), 32'd0);
        check("wr_resp_count", 32'(resp_count), 32'd1);

        // Back-to-back: three writes with req_valid held high
        wait_ready();
        resp_count = 0;
        req_valid = 1'b1; req_rw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_addr = 15'(k + 1);
            req_wdata = 8'(8'h11 * (k + 1));
            tick();
            check("b2b_data", 32'(c6502_data_out), 32'(8'h11 * (k + 1)));
            check("b2b_addr", 32'(c6502_addr), 32'(k + 1));
            if (k == 2) req_valid = 1'b0;
            n = 1;
            while (!req_ready && n < 60) begin
                tick();
                n++;
            end
            check("b2b_spacing", 32'(n), 32'd20);
            check("b2b_resp_at_slot", 32'(resp_valid), 32'd1);
        end
        check("b2b_resp_count", 32'(resp_count), 32'd3);

        // Idle for two bus periods
        resp_count = 0; rises = 0; rw_bad = 0;
        m2_prev = c6502_m2;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (c6502_m2 && !m2_prev) rises++;
            m2_prev = c6502_m2;
            if (!c6502_rw) rw_bad++;
        end
        check("idle_m2_rises", 32'(rises), 32'd2);
        check("idle_rw_high", 32'(rw_bad), 32'd0);
        check("idle_no_resp", 32'(resp_count), 32'd0);
        check("idle_addr_kept", 32'(c6502_addr), 32'd3);

        // Write aborted by reset during HIGH
        wait_ready();
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 15'h0300; req_wdata = 8'h5A;
        resp_count = 0;
        tick();
        req_valid = 1'b0;
        ticks(11);
        check("abort_oe_before", 32'(c6502_data_oe), 32'd1);
        rst = 1'b1;
        tick();
        check("abort_oe_dropped", 32'(c6502_data_oe), 32'd0);
        check("abort_m2", 32'(c6502_m2), 32'd0);
        check("abort_rw", 32'(c6502_rw), 32'd1);
        rst = 1'b0;
        ticks(30);
        check("abort_no_resp", 32'(resp_count), 32'd0);

`ifdef BUS6502_RDY_EN
        // Read stalled by RDY for two bus cycles
        wait_ready();
        c6502_rdy = 1'b0;
        c6502_data_in = 8'h77;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 15'h8000 & 15'h7FFF;
        resp_count = 0;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (resp_count == 0 && n < 100) begin
            tick();
            n++;
            if (n == 20 || n == 40) begin
                check("rdy_ready_blocked", 32'(req_ready), 32'd0);
                check("rdy_rw_held", 32'(c6502_rw), 32'd1);
            end
            if (n == 40) c6502_rdy = 1'b1;
        end
        check("rdy_latency", 32'(n), 32'd60);
        check("rdy_rdata", 32'(resp_rdata), 32'h77);
        ticks(20);
        check("rdy_resp_count", 32'(resp_count), 32'd1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
